// File: rtl/vc_test_rand_delay_source.sv
// Test source: streams a preloaded message memory onto a val/rdy interface,
// inserting a pseudo-random number of idle cycles (0..p_max_delay) before
// each message. Message order is fixed; timing is deterministic per seed.
//
// state | meaning
// IDLE  | just out of reset; next cycle draws the first delay
// DELAY | counting down idle cycles before the next message
// SEND  | val high, holding m[index] until rdy
// DONE  | all messages accepted; terminal until reset
module vc_test_rand_delay_source #(
   parameter int          p_msg_nbits = 1,
   parameter int          p_num_msgs  = 1024,
   parameter int          p_max_delay = 0,
   parameter logic [31:0] p_seed      = 32'hb9b9_b9b9
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic                   val,
   input  logic                   rdy,
   output logic [p_msg_nbits-1:0] msg,
   output logic                   done
);

   localparam int IW = (p_num_msgs < 2) ? 1 : $clog2(p_num_msgs);
   localparam int CW = (p_max_delay < 1) ? 1 : $clog2(p_max_delay + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(p_num_msgs - 1);

   typedef enum logic [1:0] {IDLE, DELAY, SEND, DONE} state_t;

   // Loaded hierarchically by the harness; never written here so it
   // survives reset and the stream replays identically.
   logic [p_msg_nbits-1:0] m [p_num_msgs-1:0];

   state_t        state_q;
   logic [IW-1:0] index_q;
   logic [31:0]   lfsr_q;
   logic [CW-1:0] cnt_q;

   logic [31:0]   lfsr_d;
   logic [31:0]   draw_d;

   // Next LFSR value and the delay drawn from the current LFSR value.
   always_comb begin
      lfsr_d = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
      draw_d = 32'd0;
      if (p_max_delay != 0)
         draw_d = 32'(lfsr_q[15:0]) % 32'(p_max_delay + 1);
   end

   // Sequencing FSM; the LFSR only advances when a delay is drawn.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         index_q <= '0;
         lfsr_q  <= p_seed;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               lfsr_q <= lfsr_d;
               if (draw_d == 32'd0) begin
                  state_q <= SEND;
               end else begin
                  state_q <= DELAY;
                  cnt_q   <= CW'(draw_d - 32'd1);
               end
            end
            DELAY: begin
               if (cnt_q == '0) state_q <= SEND;
               else             cnt_q   <= cnt_q - 1'b1;
            end
            SEND: begin
               if (rdy) begin
                  if (index_q == LAST_IDX) begin
                     state_q <= DONE;
                  end else begin
                     index_q <= index_q + 1'b1;
                     lfsr_q  <= lfsr_d;
                     if (draw_d != 32'd0) begin
                        state_q <= DELAY;
                        cnt_q   <= CW'(draw_d - 32'd1);
                     end
                  end
               end
            end
            DONE: state_q <= DONE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Outputs decode straight from registered state, never from rdy.
   always_comb begin
      val  = (state_q == SEND);
      done = (state_q == DONE);
      msg  = m[index_q];
   end

   // Interface sanity checks while out of reset.
   a_val_known: assert property (@(posedge clk) disable iff (reset) !$isunknown(val));
   a_rdy_known: assert property (@(posedge clk) disable iff (reset) val |-> !$isunknown(rdy));

endmodule

// File: tb/tb_vc_test_rand_delay_source.sv
// Bench for vc_test_rand_delay_source: a full-throughput instance and a
// random-delay instance share clock, reset and rdy; each scenario observes one.
module tb_vc_test_rand_delay_source;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rdy = 1'b0;
   logic       val0, done0, val3, done3;
   logic [7:0] msg0, msg3;

   int total = 0;
   int bad   = 0;

   logic [7:0] msgs [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
   int         exp_gap [4];
   int         obs_gap_first [4];
   int         obs_gap [4];

   always #5 clk = ~clk;

   vc_test_rand_delay_source #(.p_msg_nbits(8), .p_num_msgs(4), .p_max_delay(0),
                               .p_seed(32'hb9b9_b9b9)) dut0 (
      .clk(clk), .reset(reset), .val(val0), .rdy(rdy), .msg(msg0), .done(done0));

   vc_test_rand_delay_source #(.p_msg_nbits(8), .p_num_msgs(4), .p_max_delay(3),
                               .p_seed(32'hb9b9_b9b9)) dut3 (
      .clk(clk), .reset(reset), .val(val3), .rdy(rdy), .msg(msg3), .done(done3));

   // Reference: the gap before message k is draw k of the LFSR sequence.
   task automatic build_model();
      logic [31:0] l;
      l = 32'hb9b9_b9b9;
      for (int k = 0; k < 4; k++) begin
         exp_gap[k] = int'(l[15:0]) % 4;
         l = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
      end
   endtask

   // Holds reset two edges and releases it mid-cycle; returns in cycle 0.
   task automatic release_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      rdy   = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (val0 !== 1'b0 || done0 !== 1'b0) begin bad++;
         $display("FAIL reset_dut0 val=%b done=%b want val=0 done=0", val0, done0); end
      total++; if (msg0 !== 8'h11) begin bad++;
         $display("FAIL reset_msg0 got=%h want=11", msg0); end
      total++; if (val3 !== 1'b0 || done3 !== 1'b0 || msg3 !== 8'h11) begin bad++;
         $display("FAIL reset_dut3 val=%b done=%b msg=%h want 0 0 11", val3, done3, msg3); end
      reset = 1'b0;
      total++; if (val0 !== 1'b0) begin bad++;
         $display("FAIL cycle0_val got=%b want=0", val0); end
   endtask

   task automatic test_streaming();
      release_reset();
      rdy = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         total++; if (val0 !== 1'b1 || msg0 !== msgs[c-1]) begin bad++;
            $display("FAIL stream_c%0d val=%b msg=%h want val=1 msg=%h", c, val0, msg0, msgs[c-1]); end
      end
      for (int c = 5; c <= 7; c++) begin
         @(negedge clk);
         total++; if (val0 !== 1'b0 || done0 !== 1'b1) begin bad++;
            $display("FAIL stream_done_c%0d val=%b done=%b want val=0 done=1", c, val0, done0); end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] want;
      release_reset();
      rdy = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         rdy = (c >= 4);
         if (c <= 7) begin
            want = (c <= 4) ? 8'h11 : msgs[c-4];
            total++; if (val0 !== 1'b1 || msg0 !== want) begin bad++;
               $display("FAIL bp_c%0d val=%b msg=%h want val=1 msg=%h", c, val0, msg0, want); end
            total++; if (done0 !== 1'b0) begin bad++;
               $display("FAIL bp_early_done_c%0d got=%b want=0", c, done0); end
         end else begin
            total++; if (done0 !== 1'b1 || val0 !== 1'b0) begin bad++;
               $display("FAIL bp_done_c8 done=%b val=%b want done=1 val=0", done0, val0); end
         end
      end
   endtask

   // Starts in cycle 0 of dut3; runs until stop_after handshakes, checking
   // gap lengths, order and hold-under-backpressure against the model.
   task automatic run_stream(input int stop_after, input bit rand_rdy);
      int         k = 0;
      int         idle = 0;
      int         cyc = 0;
      bit         presenting = 0;
      bit         pv = 0;
      bit         pr = 0;
      logic [7:0] pm = 8'h00;
      while (k < stop_after && cyc < 200) begin
         @(negedge clk);
         cyc++;
         rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         if (pv && !pr) begin
            total++; if (val3 !== 1'b1 || msg3 !== pm) begin bad++;
               $display("FAIL hold_k%0d val=%b msg=%h want val=1 msg=%h", k, val3, msg3, pm); end
         end
         if (val3 === 1'b1 && !presenting) begin
            presenting = 1;
            obs_gap[k] = idle;
            total++; if (idle != exp_gap[k]) begin bad++;
               $display("FAIL gap_k%0d got=%0d want=%0d", k, idle, exp_gap[k]); end
            total++; if (msg3 !== msgs[k]) begin bad++;
               $display("FAIL order_k%0d got=%h want=%h", k, msg3, msgs[k]); end
         end else if (val3 !== 1'b1) begin
            idle++;
         end
         if (val3 === 1'b1 && rdy) begin
            k++;
            idle = 0;
            presenting = 0;
         end
         pv = (val3 === 1'b1);
         pr = rdy;
         pm = msg3;
      end
      if (k < stop_after) begin
         total++; bad++;
         $display("FAIL stream_timeout handshakes=%0d want=%0d", k, stop_after);
      end
      if (stop_after == 4) begin
         @(negedge clk);
         total++; if (done3 !== 1'b1 || val3 !== 1'b0) begin bad++;
            $display("FAIL final_done done=%b val=%b want done=1 val=0", done3, val3); end
      end
   endtask

   task automatic test_random_delay();
      release_reset();
      run_stream(4, 1'b0);
      for (int k = 0; k < 4; k++) obs_gap_first[k] = obs_gap[k];
   endtask

   task automatic test_reset_mid_stream();
      release_reset();
      run_stream(2, 1'b1);
      rdy = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      total++; if (val3 !== 1'b0 || done3 !== 1'b0 || msg3 !== 8'h11) begin bad++;
         $display("FAIL mid_reset val=%b done=%b msg=%h want 0 0 11", val3, done3, msg3); end
      reset = 1'b0;
      run_stream(4, 1'b1);
      for (int k = 0; k < 4; k++) begin
         total++; if (obs_gap[k] != obs_gap_first[k]) begin bad++;
            $display("FAIL replay_gap_k%0d got=%0d want=%0d", k, obs_gap[k], obs_gap_first[k]); end
      end
   endtask

   task automatic test_done_hold();
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         rdy = 1'($urandom_range(0, 1));
         total++; if (val3 !== 1'b0 || done3 !== 1'b1 || msg3 !== 8'h44) begin bad++;
            $display("FAIL done_hold_c%0d val=%b done=%b msg=%h want 0 1 44", c, val3, done3, msg3); end
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         dut0.m[i] = msgs[i];
         dut3.m[i] = msgs[i];
      end
      build_model();
      test_reset();
      test_streaming();
      test_backpressure();
      test_random_delay();
      test_reset_mid_stream();
      test_done_hold();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
